// File: rtl/logic_unit_pipe_pkg.sv
// Shared ALU definitions: logic-unit op codes and op-code width.
package alu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'b000;
    localparam logic [OP_W-1:0] OP_OR   = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
    localparam logic [OP_W-1:0] OP_NAND = 3'b011;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b100;
    localparam logic [OP_W-1:0] OP_XNOR = 3'b101;
    localparam logic [OP_W-1:0] OP_NOTA = 3'b110;
    localparam logic [OP_W-1:0] OP_ACCX = 3'b111;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Request/response bundle of the pipelined logic unit (valid/ready on both sides).
interface logic_unit_pipe_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OP_W-1:0]  op;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] h;
    logic             zero;
    logic             parity;

    modport master (
        output in_valid, a, b, op, acc_clr, out_ready,
        input  in_ready, out_valid, h, zero, parity
    );

    modport slave (
        input  in_valid, a, b, op, acc_clr, out_ready,
        output in_ready, out_valid, h, zero, parity
    );

endinterface

// File: rtl/logic_unit_core.sv
// Combinational bitwise logic core; op 111 folds operand A into the accumulator.
module logic_unit_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_XNOR: result = ~(a ^ b);
            OP_NOTA: result = ~a;
            OP_ACCX: result = acc ^ a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined logic unit with valid/ready handshake, result flags and a running accumulator.
module logic_unit_pipe
    import alu_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic            clk,
    input  logic            rst,
    logic_unit_pipe_if.slave bus
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [OP_W-1:0]  s1_op;

    logic             out_valid;
    logic [WIDTH-1:0] h;
    logic             zero;
    logic             parity;
    logic [WIDTH-1:0] acc;

    logic             s1_load;
    logic             s2_load;
    logic             in_ready;
    logic [WIDTH-1:0] result;

    // Ready is combinational from out_ready so a full pipe can drain and refill in one edge.
    assign s2_load  = s1_valid && (!out_valid || bus.out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign s1_load  = bus.in_valid && in_ready;

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .op     (s1_op),
        .a      (s1_a),
        .b      (s1_b),
        .acc    (acc),
        .result (result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_a     <= bus.a;
                s1_b     <= bus.b;
                s1_op    <= bus.op;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            h         <= '0;
            zero      <= 1'b1;
            parity    <= 1'b0;
        end else begin
            if (s2_load) begin
                out_valid <= 1'b1;
                h         <= result;
                zero      <= (result == '0);
                parity    <= ^result;
            end else if (bus.out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // A clear wins over the fold update; the result loaded in that same cycle already used the old acc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= ACC_INIT;
        end else if (bus.acc_clr) begin
            acc <= ACC_INIT;
        end else if (s2_load) begin
            acc <= result;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.h         = h;
    assign bus.zero      = zero;
    assign bus.parity    = parity;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed steps plus random ops against an in-order result model.
module tb_logic_unit_pipe;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic_unit_pipe_if #(.WIDTH(8)) bus ();

    logic_unit_pipe #(.WIDTH(8), .ACC_INIT(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    logic [7:0] model_acc = 8'h00;
    logic       fire_in;
    logic       fire_out;
    logic       last_zero;
    logic       last_parity;

    // Reference behaviour: results are produced strictly in acceptance order, and the
    // accumulator is simply the previous result unless cleared.
    function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return x ^ y;
            3'd3:    return ~(x & y);
            3'd4:    return ~(x | y);
            3'd5:    return ~(x ^ y);
            3'd6:    return ~x;
            default: return model_acc ^ x;
        endcase
    endfunction

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: observe both handshakes mid-cycle, score outputs, log accepts, advance.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        fire_in  = bus.in_valid && bus.in_ready;
        fire_out = bus.out_valid && bus.out_ready;
        if (fire_out) begin
            obs_q.push_back(bus.h);
            last_zero   = bus.zero;
            last_parity = bus.parity;
            if (exp_q.size() == 0) begin
                check_output("unexpected_output", 32'(bus.h), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_output("h", 32'(bus.h), 32'(e));
                check_output("zero", 32'(bus.zero), 32'(e == 8'h00));
                check_output("parity", 32'(bus.parity), 32'(^e));
            end
        end
        if (fire_in) begin
            e = model(bus.op, bus.a, bus.b);
            model_acc = e;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [7:0] x, input logic [7:0] y, input logic [2:0] o);
        bit done = 0;
        bus.a        = x;
        bus.b        = y;
        bus.op       = o;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10 && !done; i++) begin
            tick();
            if (fire_in) done = 1;
        end
        check_output("accept_in_time", 32'(done), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || bus.out_valid); i++) tick();
        check_output("drained", 32'(exp_q.size()), 32'd0);
    endtask

    logic [7:0] sweep_exp [7] = '{8'h48, 8'hDE, 8'h96, 8'hB7, 8'h21, 8'h69, 8'h35};
    logic [7:0] held_h;
    logic [7:0] ops_a [3];
    logic [2:0] ops_op [3];
    int         idx;
    int         base;

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = '0;
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b1;

        // Power-on reset values
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_output("rst_h", 32'(bus.h), 32'd0);
        check_output("rst_zero", 32'(bus.zero), 32'd1);
        check_output("rst_parity", 32'(bus.parity), 32'd0);
        check_output("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;

        // Reset mid-stream discards in-flight ops without a clock edge
        bus.out_ready = 1'b0;
        apply_stimulus(8'hF0, 8'h0F, OP_OR);
        apply_stimulus(8'h33, 8'h11, OP_OR);
        tick();
        check_output("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        check_output("pre_rst_in_ready", 32'(bus.in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check_output("async_out_valid", 32'(bus.out_valid), 32'd0);
        check_output("async_h", 32'(bus.h), 32'd0);
        check_output("async_zero", 32'(bus.zero), 32'd1);
        check_output("async_parity", 32'(bus.parity), 32'd0);
        check_output("async_in_ready", 32'(bus.in_ready), 32'd1);
        exp_q.delete();
        model_acc = 8'h00;
        @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        apply_stimulus(8'h5A, 8'h00, OP_ACCX);
        drain();
        check_output("acc_after_reset", 32'(obs_q[obs_q.size()-1]), 32'h5A);

        // Op sweep with two-edge latency
        for (int i = 0; i < 7; i++) begin
            bus.a        = 8'hCA;
            bus.b        = 8'h5C;
            bus.op       = 3'(i);
            bus.in_valid = 1'b1;
            tick();
            check_output("sweep_accept", 32'(fire_in), 32'd1);
            bus.in_valid = 1'b0;
            check_output("sweep_lat_edge1", 32'(bus.out_valid), 32'd0);
            tick();
            check_output("sweep_lat_edge2", 32'(bus.out_valid), 32'd1);
            check_output("sweep_h", 32'(bus.h), 32'(sweep_exp[i]));
            check_output("sweep_zero", 32'(bus.zero), 32'd0);
        end
        drain();

        // Stall: three ops back-to-back with the consumer blocked
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ops_a[i]  = 8'($urandom);
            ops_op[i] = 3'($urandom_range(0, 6));
        end
        base = obs_q.size();
        idx  = 0;
        bus.a = ops_a[0]; bus.b = 8'hA5; bus.op = ops_op[0]; bus.in_valid = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick();
            if (c == 1) held_h = bus.h;
            if (c > 1) check_output("stall_h_stable", 32'(bus.h), 32'(held_h));
            if (fire_in) begin
                idx++;
                if (idx < 3) begin
                    bus.a = ops_a[idx]; bus.op = ops_op[idx];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        check_output("stall_accepts", 32'(idx), 32'd2);
        check_output("stall_in_ready", 32'(bus.in_ready), 32'd0);
        check_output("stall_out_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && (idx < 3 || exp_q.size() != 0); c++) begin
            tick();
            if (fire_in) begin
                idx++;
                bus.in_valid = 1'b0;
            end
        end
        check_output("stall_all_accepted", 32'(idx), 32'd3);
        drain();
        check_output("stall_delivered", 32'(obs_q.size() - base), 32'd3);

        // Streaming random ops at full throughput
        base = obs_q.size();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.a        = 8'($urandom);
            bus.b        = 8'($urandom);
            bus.op       = 3'($urandom_range(0, 7));
            bus.in_valid = 1'b1;
            tick();
            check_output("stream_in_ready", 32'(fire_in), 32'd1);
        end
        bus.in_valid = 1'b0;
        drain();
        check_output("stream_delivered", 32'(obs_q.size() - base), 32'd16);

        // Accumulator fold chain after a clear
        bus.acc_clr = 1'b1;
        tick();
        bus.acc_clr = 1'b0;
        model_acc = 8'h00;
        base = obs_q.size();
        apply_stimulus(8'h0F, 8'h00, OP_ACCX);
        apply_stimulus(8'hF0, 8'h00, OP_ACCX);
        apply_stimulus(8'hFF, 8'h00, OP_ACCX);
        drain();
        check_output("fold_0", 32'(obs_q[base]), 32'h0F);
        check_output("fold_1", 32'(obs_q[base+1]), 32'hFF);
        check_output("fold_2", 32'(obs_q[base+2]), 32'h00);
        check_output("fold_zero", 32'(last_zero), 32'd1);
        check_output("fold_parity", 32'(last_parity), 32'd0);

        // Clear coinciding with the S2 load of a fold op
        apply_stimulus(8'h3C, 8'h00, OP_OR);
        drain();
        apply_stimulus(8'h03, 8'h00, OP_ACCX);
        bus.acc_clr = 1'b1;
        tick();
        bus.acc_clr = 1'b0;
        model_acc = 8'h00;
        drain();
        check_output("clr_same_cycle", 32'(obs_q[obs_q.size()-1]), 32'h3F);
        apply_stimulus(8'h01, 8'h00, OP_ACCX);
        drain();
        check_output("clr_after", 32'(obs_q[obs_q.size()-1]), 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
